alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu32_pkg.sv | 23 ++
 rtl/fifo_mem.sv | 22 ++
 rtl/alu_result_fifo.sv | 79 +++++++
 tb/tb_alu_result_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// alu32_pkg: shared ALU opcodes, default result-FIFO geometry and the result flag helper
package alu32_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_DEPTH = 8;

    typedef enum logic [3:0] {
        NOP   = 4'h0,
        NOT_A = 4'h1,
        AND   = 4'h2,
        OR    = 4'h3,
        XOR   = 4'h4,
        XNOR  = 4'h5,
        ADD   = 4'h6,
        SUB   = 4'h7
    } alu_op_e;

    // {zero, neg} of the 32-bit result view
    function automatic logic [1:0] result_flags(input logic [31:0] r);
        return {r == 32'd0, r[31]};
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-array storage with synchronous write and asynchronous read
module fifo_mem #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FIFO of ALU results with opcode; per-entry zero/neg flags when ALU_FIFO_FLAGS_EN is defined
module alu_result_fifo
    import alu32_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = ALU_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [3:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_op,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
`ifdef ALU_FIFO_FLAGS_EN
    localparam int EW = WIDTH + 6;
`else
    localparam int EW = WIDTH + 4;
`endif

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] wr_entry, rd_entry;
    logic          push, pop;

    // extra pointer MSB separates a wrapped (full) writer from an equal (empty) one
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

`ifdef ALU_FIFO_FLAGS_EN
    assign wr_entry = {result_flags(in_result[31:0]), in_op, in_result};
    assign {out_zero, out_neg, out_op, out_result} = rd_entry;
`else
    assign wr_entry = {in_op, in_result};
    assign {out_op, out_result} = rd_entry;
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

    fifo_mem #(
        .WIDTH(EW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(wr_entry),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rd_entry)
    );

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed and random stimulus checked against a queue model of alu_result_fifo
module tb_alu_result_fifo;

    localparam int W = 64;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_result = '0;
    logic [3:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic [3:0]   out_op;
    logic         out_zero;
    logic         out_neg;
    logic [3:0]   count;
    logic         full;
    logic         empty;

    logic [W+3:0] q[$];
    int           total = 0;
    int           bad = 0;

    alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] h;
        logic         ez, en;
        chk("count", W'(count), W'(q.size()));
        chk("full", W'(full), W'(q.size() == D));
        chk("empty", W'(empty), W'(q.size() == 0));
        chk("in_ready", W'(in_ready), W'(q.size() != D));
        chk("out_valid", W'(out_valid), W'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0][W-1:0];
`ifdef ALU_FIFO_FLAGS_EN
            ez = h[31:0] == 32'd0;
            en = h[31];
`else
            ez = 1'b0;
            en = 1'b0;
`endif
            chk("out_result", out_result, h);
            chk("out_op", W'(out_op), W'(q[0][W+3:W]));
            chk("out_zero", W'(out_zero), W'(ez));
            chk("out_neg", W'(out_neg), W'(en));
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] r, input logic [3:0] op,
                        input logic ordy, input logic rs);
        logic do_push, do_pop;
        in_valid  = v;
        in_result = r;
        in_op     = op;
        out_ready = ordy;
        rst       = rs;
        @(posedge clk);
        if (rs) q.delete();
        else begin
            do_pop  = ordy && q.size() != 0;
            do_push = v && q.size() < D;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({op, r});
        end
        #1;
        check_all();
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: r[31:0] = 32'd0;
            1: r[31] = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // fill to full, then a refused ninth push
        for (int i = 1; i <= 8; i++) step(1, W'(i), 4'(i % 8), 0, 0);
        step(1, 64'h9, 4'h1, 0, 0);
        chk("full_after9", W'(full), 1);
        chk("count_after9", W'(count), 8);
        // full with pop requested: push still refused
        step(1, 64'hA, 4'h2, 1, 0);
        step(1, 64'hB, 4'h3, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
        chk("empty_drained", W'(empty), 1);
        // steady push+pop at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1, rand_word(), 4'($urandom_range(0, 7)), 0, 0);
        for (int i = 0; i < 20; i++) step(1, rand_word(), 4'($urandom_range(0, 7)), 1, 0);
        chk("count_steady", W'(count), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        // push and pop together into an empty FIFO
        step(1, 64'h5, 4'h6, 1, 0);
        chk("empty_pushpop", out_result, 64'h5);
        step(0, 0, 0, 1, 0);
        // flag patterns
        step(1, 64'h0, 4'h7, 0, 0);
        step(1, 64'h8000_0000, 4'h6, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // reset mid-operation at count 5, with a push offered
        for (int i = 0; i < 5; i++) step(1, rand_word(), 4'($urandom_range(0, 7)), 0, 0);
        chk("count_pre_rst", W'(count), 5);
        step(1, 64'h77, 4'h1, 1, 1);
        chk("count_rst", W'(count), 0);
        // random traffic with varying push/pop pressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            int pv, pr;
            pv = (i / 500) % 2 ? 80 : 40;
            pr = (i / 500) % 2 ? 40 : 80;
            step($urandom_range(0, 99) < pv, rand_word(), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < pr, $urandom_range(0, 399) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
